// File: rtl/transport_tx_buffer_pkg.sv
// Shared definitions for the transport TX buffer: FSM states and the
// data-bus codes it shares with control_fsm and data_bus.
package transport_tx_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // d_sel code under which data_bus carries transport data.
    localparam logic [3:0] D_SEL_DATA_CODE = 4'd8;

    // Byte placed on the logical-layer input whenever no data is sent.
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

endpackage

// File: rtl/transport_tx_buffer_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection and a
// synchronous flush. Head entry is read combinationally (no fall-through).
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/transport_tx_buffer.sv
// Elastic TX byte buffer between transport and logical layer: stores
// packet-delimited bytes and releases a packet once it is complete or deep enough.
module transport_tx_buffer
    import transport_tx_buffer_pkg::*;
#(
    parameter int               DEPTH      = 16,
    parameter int               WIDTH      = 8,
    parameter int               START_TH   = 8,
    parameter logic [WIDTH-1:0] IDLE_BYTE  = WIDTH'(IDLE_BYTE_DEFAULT),
    parameter logic [3:0]       D_SEL_DATA = D_SEL_DATA_CODE
) (
    input  logic                   fsm_clk,
    input  logic                   reset_n,
    input  logic                   tl_valid,
    input  logic [WIDTH-1:0]       tl_data,
    input  logic                   tl_last,
    output logic                   tl_ready,
    input  logic                   tx_lanes_on,
    input  logic [3:0]             d_sel,
    input  logic                   lane_disable,
    output logic [WIDTH-1:0]       transport_layer_data_in,
    output logic                   tx_data_valid,
    output logic                   underflow,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [$clog2(DEPTH):0] pkt_count,
    output state_t                 fsm_state
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   START_TH_C = CW'(START_TH);

    state_t           state, state_next;
    logic             full, empty;
    logic [WIDTH:0]   head;
    logic             push, pop, consume;
    logic             out_load, out_valid, underflow_next;
    logic [WIDTH-1:0] out_byte;

    // Handshake: a byte transfers on every edge where tl_valid && tl_ready;
    // tl_valid may be held across cycles, tl_ready depends only on registered
    // state plus lane_disable, and a blocked byte must be held stable.
    assign tl_ready = reset_n && !full && !lane_disable;
    assign push     = tl_valid && tl_ready;
    assign consume  = tx_lanes_on && (d_sel == D_SEL_DATA);

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (fsm_clk),
        .reset_n (reset_n),
        .flush   (lane_disable),
        .push    (push),
        .wdata   ({tl_last, tl_data}),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        out_load       = 1'b0;
        out_byte       = IDLE_BYTE;
        out_valid      = 1'b0;
        underflow_next = 1'b0;
        if (lane_disable) begin
            state_next = ST_FLUSH;
            out_load   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (consume) begin
                        out_load = 1'b1;
                        if (pkt_count != '0 || fifo_level >= START_TH_C) begin
                            pop        = 1'b1;
                            out_byte   = head[WIDTH-1:0];
                            out_valid  = 1'b1;
                            // A single-byte packet ends on its start cycle.
                            state_next = head[WIDTH] ? ST_IDLE : ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (consume) begin
                        out_load = 1'b1;
                        if (!empty) begin
                            pop       = 1'b1;
                            out_byte  = head[WIDTH-1:0];
                            out_valid = 1'b1;
                            if (head[WIDTH]) state_next = ST_IDLE;
                        end else begin
                            underflow_next = 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    out_load   = 1'b1;
                    state_next = ST_IDLE;
                end
                default: begin
                    out_load   = 1'b1;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge fsm_clk) begin
        if (!reset_n) begin
            state                   <= ST_IDLE;
            transport_layer_data_in <= IDLE_BYTE;
            tx_data_valid           <= 1'b0;
            underflow               <= 1'b0;
        end else begin
            state     <= state_next;
            underflow <= underflow_next;
            if (out_load) begin
                transport_layer_data_in <= out_byte;
                tx_data_valid           <= out_valid;
            end
        end
    end

    // Complete packets in storage: counted in on a last push, out on a last pop.
    always_ff @(posedge fsm_clk) begin
        if (!reset_n || lane_disable) begin
            pkt_count <= '0;
        end else begin
            pkt_count <= pkt_count + CW'(push && tl_last) - CW'(pop && head[WIDTH]);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_transport_tx_buffer.sv
// Directed bench for transport_tx_buffer: packet streaming, threshold start,
// full, flush, full-rate wrap-around and mid-stream reset.
module tb_transport_tx_buffer;
    import transport_tx_buffer_pkg::*;

    logic       fsm_clk = 1'b0;
    logic       reset_n;
    logic       tl_valid;
    logic [7:0] tl_data;
    logic       tl_last;
    logic       tl_ready;
    logic       tx_lanes_on;
    logic [3:0] d_sel;
    logic       lane_disable;
    logic [7:0] transport_layer_data_in;
    logic       tx_data_valid;
    logic       underflow;
    logic [4:0] fifo_level;
    logic [4:0] pkt_count;
    state_t     fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    transport_tx_buffer dut (
        .fsm_clk                 (fsm_clk),
        .reset_n                 (reset_n),
        .tl_valid                (tl_valid),
        .tl_data                 (tl_data),
        .tl_last                 (tl_last),
        .tl_ready                (tl_ready),
        .tx_lanes_on             (tx_lanes_on),
        .d_sel                   (d_sel),
        .lane_disable            (lane_disable),
        .transport_layer_data_in (transport_layer_data_in),
        .tx_data_valid           (tx_data_valid),
        .underflow               (underflow),
        .fifo_level              (fifo_level),
        .pkt_count               (pkt_count),
        .fsm_state               (fsm_state)
    );

    always #5 fsm_clk = ~fsm_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fsm_clk);
        #1;
    endtask

    task automatic set_consume(input logic on);
        tx_lanes_on = on;
        d_sel       = on ? D_SEL_DATA_CODE : 4'd0;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last);
        tl_valid = 1'b1;
        tl_data  = d;
        tl_last  = last;
        tick();
        tl_valid = 1'b0;
        tl_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic v);
        check_eq({tag, "_data"}, 32'(transport_layer_data_in), 32'(d));
        check_eq({tag, "_valid"}, 32'(tx_data_valid), 32'(v));
    endtask

    initial begin
        reset_n      = 1'b0;
        tl_valid     = 1'b0;
        tl_data      = 8'h00;
        tl_last      = 1'b0;
        lane_disable = 1'b0;
        set_consume(1'b0);

        // Reset state
        tick();
        tick();
        check_out("rst", 8'h00, 1'b0);
        check_eq("rst_level", 32'(fifo_level), 0);
        check_eq("rst_pkt", 32'(pkt_count), 0);
        check_eq("rst_uflow", 32'(underflow), 0);
        check_eq("rst_ready", 32'(tl_ready), 0);
        check_eq("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        tick();
        check_eq("rst_ready_rel", 32'(tl_ready), 1);

        // 1: complete 3-byte packet
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b1);
        check_eq("t1_level", 32'(fifo_level), 3);
        check_eq("t1_pkt", 32'(pkt_count), 1);
        set_consume(1'b1);
        tick();
        check_out("t1_b0", 8'h11, 1'b1);
        check_eq("t1_state0", 32'(fsm_state), 32'(ST_STREAM));
        tick();
        check_out("t1_b1", 8'h22, 1'b1);
        tick();
        check_out("t1_b2", 8'h33, 1'b1);
        check_eq("t1_pkt_end", 32'(pkt_count), 0);
        check_eq("t1_state2", 32'(fsm_state), 32'(ST_IDLE));
        tick();
        check_out("t1_idle", 8'h00, 1'b0);

        // 2: threshold start, then underflow
        for (int k = 1; k <= 10; k++) begin
            push_byte(8'h40 + 8'(k), 1'b0);
            if (k == 8) begin
                check_eq("t2_wait_state", 32'(fsm_state), 32'(ST_IDLE));
                check_eq("t2_wait_valid", 32'(tx_data_valid), 0);
            end
            if (k == 9) check_out("t2_first", 8'h41, 1'b1);
            if (k == 10) check_eq("t2_level", 32'(fifo_level), 8);
        end
        for (int k = 3; k <= 10; k++) begin
            tick();
            check_out("t2_drain", 8'h40 + 8'(k), 1'b1);
        end
        tick();
        check_out("t2_uf", 8'h00, 1'b0);
        check_eq("t2_uf_pulse", 32'(underflow), 1);
        check_eq("t2_uf_state", 32'(fsm_state), 32'(ST_STREAM));
        set_consume(1'b0);
        tick();
        check_eq("t2_uf_clear", 32'(underflow), 0);
        check_eq("t2_hold_state", 32'(fsm_state), 32'(ST_STREAM));
        push_byte(8'h5F, 1'b1);
        check_eq("t2_pkt", 32'(pkt_count), 1);
        set_consume(1'b1);
        tick();
        set_consume(1'b0);
        check_out("t2_last", 8'h5F, 1'b1);
        check_eq("t2_end_state", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("t2_end_pkt", 32'(pkt_count), 0);

        // 3: fill to 16 and block a 17th byte
        for (int k = 0; k < 16; k++) push_byte(8'h80 + 8'(k), 1'b0);
        check_eq("t3_level", 32'(fifo_level), 16);
        check_eq("t3_ready", 32'(tl_ready), 0);
        check_out("t3_hold", 8'h5F, 1'b1);
        tl_valid = 1'b1;
        tl_data  = 8'hEE;
        tick();
        check_eq("t3_no_push", 32'(fifo_level), 16);
        set_consume(1'b1);
        tick();
        tl_valid = 1'b0;
        set_consume(1'b0);
        check_out("t3_pop", 8'h80, 1'b1);
        check_eq("t3_ready_back", 32'(tl_ready), 1);
        check_eq("t3_level_pop", 32'(fifo_level), 15);

        // 4: flush mid-packet
        lane_disable = 1'b1;
        tick();
        lane_disable = 1'b0;
        tick();
        for (int k = 1; k <= 5; k++) push_byte(8'hC0 + 8'(k), 1'b0);
        check_eq("t4_level_pre", 32'(fifo_level), 5);
        lane_disable = 1'b1;
        tl_valid     = 1'b1;
        tl_data      = 8'hC6;
        tick();
        tl_valid = 1'b0;
        check_eq("t4_level", 32'(fifo_level), 0);
        check_eq("t4_pkt", 32'(pkt_count), 0);
        check_out("t4_out", 8'h00, 1'b0);
        check_eq("t4_ready", 32'(tl_ready), 0);
        check_eq("t4_state", 32'(fsm_state), 32'(ST_FLUSH));
        lane_disable = 1'b0;
        tick();
        check_eq("t4_exit", 32'(fsm_state), 32'(ST_IDLE));
        push_byte(8'hA5, 1'b1);
        set_consume(1'b1);
        tick();
        set_consume(1'b0);
        check_out("t4_first", 8'hA5, 1'b1);

        // 5: full-rate push and consume over 64 bytes with wrap
        set_consume(1'b1);
        for (int c = 1; c <= 73; c++) begin
            if (c <= 64) begin
                tl_valid = 1'b1;
                tl_data  = 8'((c * 37 + 5) & 8'hFF);
                tl_last  = (c == 64);
                exp_q.push_back(tl_data);
            end else begin
                tl_valid = 1'b0;
                tl_last  = 1'b0;
            end
            tick();
            if (c >= 9 && c <= 64) check_eq("t5_level", 32'(fifo_level), 8);
            if (tx_data_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("t5_extra", 32'(transport_layer_data_in), 32'hFFFF_FFFF);
                end else begin
                    check_eq("t5_data", 32'(transport_layer_data_in), 32'(exp_q.pop_front()));
                end
            end
        end
        check_eq("t5_all_out", 32'(exp_q.size()), 0);
        check_eq("t5_end_state", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("t5_end_valid", 32'(tx_data_valid), 0);
        set_consume(1'b0);

        // 6: reset mid-stream
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        push_byte(8'h03, 1'b1);
        set_consume(1'b1);
        tick();
        check_out("t6_b0", 8'h01, 1'b1);
        reset_n = 1'b0;
        tick();
        check_out("t6_rst", 8'h00, 1'b0);
        check_eq("t6_level", 32'(fifo_level), 0);
        check_eq("t6_pkt", 32'(pkt_count), 0);
        check_eq("t6_state", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("t6_ready", 32'(tl_ready), 0);
        check_eq("t6_uflow", 32'(underflow), 0);
        reset_n = 1'b1;
        tick();
        check_out("t6_after", 8'h00, 1'b0);
        check_eq("t6_after_state", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("t6_after_ready", 32'(tl_ready), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
